vga_bounce_engine: RTL and testbench

Parametrised motion engine for the VGA screensaver. It keeps NUM_OBJ bouncing objects (x/y position and direction), advances all of them once per frame on a frame strobe, and reflects each object off the screen edges. It also supplies a per-pixel hit vector to the pixel pipeline. It sits between the VGA timing generator, which supplies frame_tick, hpos and vpos, and the colour mixer, which consumes hit and bounce_pulse.

---
 rtl/vga_bounce_engine.sv | 191 +++++++++++++++++++
 tb/tb_vga_bounce_engine.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_engine.sv
// Motion engine for the VGA screensaver: keeps NUM_OBJ bouncing objects,
// steps them one at a time through a shared add/compare datapath after each
// frame strobe, reflects them off the screen edges and flags beam hits.
module vga_bounce_engine #(
  parameter int NUM_OBJ  = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OBJ_W    = 64,
  parameter int OBJ_H    = 32,
  parameter int POS_W    = 10,
  parameter int SPEED_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic                     pause,
  input  logic [SPEED_W-1:0]       speed,
  input  logic [POS_W-1:0]         hpos,
  input  logic [POS_W-1:0]         vpos,
  output logic [NUM_OBJ*POS_W-1:0] obj_x,
  output logic [NUM_OBJ*POS_W-1:0] obj_y,
  output logic [NUM_OBJ-1:0]       hit,
  output logic [NUM_OBJ-1:0]       bounce_pulse,
  output logic                     busy,
  output logic                     overrun
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OBJ - 1);

  // Limits and object extents held one bit wider than a position so that
  // sums and compares can never wrap.
  localparam logic [POS_W:0] XMAX  = (POS_W+1)'(H_ACTIVE - OBJ_W);
  localparam logic [POS_W:0] YMAX  = (POS_W+1)'(V_ACTIVE - OBJ_H);
  localparam logic [POS_W:0] EXT_W = (POS_W+1)'(OBJ_W);
  localparam logic [POS_W:0] EXT_H = (POS_W+1)'(OBJ_H);

  typedef enum logic {IDLE, UPDATE} state_t;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             neg;
    logic             bounce;
  } axis_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;

  logic [POS_W-1:0] pos_x [NUM_OBJ];
  logic [POS_W-1:0] pos_y [NUM_OBJ];
  logic             neg_x [NUM_OBJ];
  logic             neg_y [NUM_OBJ];

  axis_t step_x_p0, step_y_p0;

  // One axis step, saturated against the walls [0, lim]. A zero step never
  // moves or reflects, even when the object already touches a wall; landing
  // exactly on a wall counts as a reflection.
  function automatic axis_t sat_step(input logic [POS_W-1:0]   pos,
                                     input logic               neg,
                                     input logic [SPEED_W-1:0] s,
                                     input logic [POS_W:0]     lim);
    logic [POS_W:0] p_ext;
    logic [POS_W:0] s_ext;
    logic [POS_W:0] sum;
    logic [POS_W:0] diff;
    axis_t          r;
    p_ext    = {1'b0, pos};
    s_ext    = (POS_W+1)'(s);
    sum      = p_ext + s_ext;
    diff     = p_ext - s_ext;
    r.pos    = pos;
    r.neg    = neg;
    r.bounce = 1'b0;
    if (s != '0) begin
      if (!neg) begin
        if (sum >= lim) begin
          r.pos    = lim[POS_W-1:0];
          r.neg    = 1'b1;
          r.bounce = 1'b1;
        end else begin
          r.pos = sum[POS_W-1:0];
        end
      end else begin
        if (p_ext <= s_ext) begin
          r.pos    = '0;
          r.neg    = 1'b0;
          r.bounce = 1'b1;
        end else begin
          r.pos = diff[POS_W-1:0];
        end
      end
    end
    return r;
  endfunction

  // State register for the update sequencer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: start a pass on an accepted tick, walk idx over all objects.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (frame_tick && !pause) begin
          state_nxt = UPDATE;
          idx_nxt   = '0;
        end
      end
      UPDATE: begin
        if (idx == IDX_LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == UPDATE);

  // Sticky flag for frame strobes that land while a pass is still running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (frame_tick && !pause && busy) begin
      overrun <= 1'b1;
    end
  end

  // Shared datapath: operands of the object selected by idx.
  always_comb begin
    step_x_p0 = sat_step(pos_x[idx], neg_x[idx], speed, XMAX);
    step_y_p0 = sat_step(pos_y[idx], neg_y[idx], speed, YMAX);
  end

  // Object state write-back; a corner reflection still gives a single pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        pos_x[i] <= POS_W'(i * OBJ_W);
        pos_y[i] <= POS_W'(i * OBJ_H);
        neg_x[i] <= 1'b0;
        neg_y[i] <= ((i % 2) == 1);
      end
      bounce_pulse <= '0;
    end else begin
      bounce_pulse <= '0;
      if (state == UPDATE) begin
        pos_x[idx]        <= step_x_p0.pos;
        neg_x[idx]        <= step_x_p0.neg;
        pos_y[idx]        <= step_y_p0.pos;
        neg_y[idx]        <= step_y_p0.neg;
        bounce_pulse[idx] <= step_x_p0.bounce | step_y_p0.bounce;
      end
    end
  end

  // Flatten the position arrays onto the packed output buses.
  always_comb begin
    obj_x = '0;
    obj_y = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_x[i*POS_W +: POS_W] = pos_x[i];
      obj_y[i*POS_W +: POS_W] = pos_y[i];
    end
  end

  // Beam-inside-object test; right and bottom edges are exclusive.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      hit[i] = ({1'b0, hpos} >= {1'b0, pos_x[i]}) &&
               ({1'b0, hpos} <  ({1'b0, pos_x[i]} + EXT_W)) &&
               ({1'b0, vpos} >= {1'b0, pos_y[i]}) &&
               ({1'b0, vpos} <  ({1'b0, pos_y[i]} + EXT_H));
    end
  end

endmodule

// File: tb/tb_vga_bounce_engine.sv
// Scoreboard bench for vga_bounce_engine: a plain-integer motion model
// predicts positions and reflections per frame; a monitor compares them when
// each update pass ends, directed sequences check timing and edge cases.
module tb_vga_bounce_engine;

  localparam int N        = 2;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int OBJ_W    = 64;
  localparam int OBJ_H    = 32;
  localparam int POS_W    = 10;
  localparam int SPEED_W  = 3;
  localparam int XMAX     = H_ACTIVE - OBJ_W;
  localparam int YMAX     = V_ACTIVE - OBJ_H;

  logic               clk;
  logic               rst_n;
  logic               frame_tick;
  logic               pause;
  logic [SPEED_W-1:0] speed;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic [N*POS_W-1:0] obj_x;
  logic [N*POS_W-1:0] obj_y;
  logic [N-1:0]       hit;
  logic [N-1:0]       bounce_pulse;
  logic               busy;
  logic               overrun;

  vga_bounce_engine #(
    .NUM_OBJ(N), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .OBJ_W(OBJ_W),
    .OBJ_H(OBJ_H), .POS_W(POS_W), .SPEED_W(SPEED_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
    .speed(speed), .hpos(hpos), .vpos(vpos), .obj_x(obj_x), .obj_y(obj_y),
    .hit(hit), .bounce_pulse(bounce_pulse), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][POS_W-1:0] x;
    logic [N-1:0][POS_W-1:0] y;
    logic [N-1:0]            b;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  bit   aborted = 0;
  bit   busy_prev = 0;
  int   pcnt [N];

  int mx [N];
  int my [N];
  int mdx [N];
  int mdy [N];

  logic [N*POS_W-1:0] hx [0:N+2];
  logic [N*POS_W-1:0] hy [0:N+2];
  logic [N-1:0]       hbp [0:N+2];
  logic               hbusy [0:N+2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int fld(input logic [N*POS_W-1:0] v, input int i);
    return int'(v[i*POS_W +: POS_W]);
  endfunction

  // Reference motion model in plain integers.
  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = i * OBJ_W;
      my[i]  = i * OBJ_H;
      mdx[i] = 1;
      mdy[i] = (i % 2 == 0) ? 1 : -1;
    end
  endfunction

  function automatic void move(input int p, input int d, input int s, input int lim,
                               output int np, output int nd, output bit b);
    np = p;
    nd = d;
    b  = 0;
    if (s == 0) return;
    if (d > 0) begin
      if (p + s >= lim) begin np = lim; nd = -1; b = 1; end
      else np = p + s;
    end else begin
      if (p <= s) begin np = 0; nd = 1; b = 1; end
      else np = p - s;
    end
  endfunction

  function automatic exp_t model_step(input int s);
    exp_t e;
    int np, nd;
    bit bx, by;
    for (int i = 0; i < N; i++) begin
      move(mx[i], mdx[i], s, XMAX, np, nd, bx);
      mx[i] = np; mdx[i] = nd;
      move(my[i], mdy[i], s, YMAX, np, nd, by);
      my[i] = np; mdy[i] = nd;
      e.x[i] = POS_W'(mx[i]);
      e.y[i] = POS_W'(my[i]);
      e.b[i] = bx | by;
    end
    return e;
  endfunction

  function automatic logic [N-1:0] model_hit(input int h, input int v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = (h >= mx[i]) && (h < mx[i] + OBJ_W) && (v >= my[i]) && (v < my[i] + OBJ_H);
    return r;
  endfunction

  // Monitor: when a pass ends (busy falls) pop the prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (bounce_pulse[i] === 1'b1) pcnt[i]++;
      if (busy_prev && busy === 1'b0) begin
        chk("pass_was_expected", (sb_q.size() > 0) || aborted, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          for (int i = 0; i < N; i++) begin
            chk($sformatf("sb_obj%0d_x", i), fld(obj_x, i), e.x[i]);
            chk($sformatf("sb_obj%0d_y", i), fld(obj_y, i), e.y[i]);
            chk($sformatf("sb_obj%0d_pulses", i), pcnt[i], e.b[i]);
          end
        end else begin
          aborted = 0;
        end
        for (int i = 0; i < N; i++) pcnt[i] = 0;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) pcnt[i] = 0;
  endtask

  // Accepted tick sampled at the next edge T; snapshots cycles T+1..T+N+2.
  task automatic tick();
    sb_q.push_back(model_step(int'(speed)));
    frame_tick = 1'b1;
    pause      = 1'b0;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    for (int k = 1; k <= N + 2; k++) begin
      @(negedge clk);
      hx[k] = obj_x; hy[k] = obj_y; hbp[k] = bounce_pulse; hbusy[k] = busy;
    end
    @(posedge clk); #1;
  endtask

  task automatic pause_tick();
    frame_tick = 1'b1;
    pause      = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    pause      = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("pause_busy", busy, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_first_tick();
    speed = 3'd3;
    tick();
    chk("t1_busy", hbusy[1], 1);
    chk("t2_busy", hbusy[2], 1);
    chk("t3_busy", hbusy[3], 0);
    chk("t1_obj0_x_old", fld(hx[1], 0), 0);
    chk("t2_obj0_x", fld(hx[2], 0), 3);
    chk("t2_obj0_y", fld(hy[2], 0), 3);
    chk("t2_obj1_x_old", fld(hx[2], 1), 64);
    chk("t3_obj1_x", fld(hx[3], 1), 67);
    chk("t3_obj1_y", fld(hy[3], 1), 29);
    chk("first_no_bounce", hbp[1] | hbp[2] | hbp[3] | hbp[4], 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_obj0_x"}, fld(obj_x, 0), 0);
    chk({tag, "_obj0_y"}, fld(obj_y, 0), 0);
    chk({tag, "_obj1_x"}, fld(obj_x, 1), 64);
    chk({tag, "_obj1_y"}, fld(obj_y, 1), 32);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bounce"}, bounce_pulse, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int r, h, v, j;
    rst_n = 1'b0; frame_tick = 1'b0; pause = 1'b0;
    speed = '0; hpos = '0; vpos = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset state and hit edges.
    check_reset_state("rst");
    hpos = 10'd10; vpos = 10'd5; #1;
    chk("hit_10_5", hit, 2'b01);
    hpos = 10'd64; #1;
    chk("hit_64_5_bit0", hit[0], 0);
    chk("hit_64_5", hit, model_hit(64, 5));
    hpos = 10'd63; vpos = 10'd31; #1;
    chk("hit_63_31", hit, 2'b01);
    hpos = 10'd64; vpos = 10'd32; #1;
    chk("hit_64_32", hit, 2'b10);
    hpos = 10'd128; vpos = 10'd63; #1;
    chk("hit_128_63", hit, model_hit(128, 63));

    // Single tick timing.
    check_first_tick();

    // Top/bottom reflection of object 1 at speed 3.
    do_reset();
    speed = 3'd3;
    repeat (10) tick();
    chk("s3_obj1_y_10", fld(obj_y, 1), 2);
    tick();
    chk("s3_obj1_y_11", fld(hy[3], 1), 0);
    chk("s3_pulse_before", hbp[2], 0);
    chk("s3_pulse", hbp[3], 2'b10);
    chk("s3_pulse_after", hbp[4], 0);
    tick();
    chk("s3_obj1_y_12", fld(obj_y, 1), 3);

    // Exact wall landing at speed 7.
    do_reset();
    speed = 3'd7;
    repeat (63) tick();
    tick();
    chk("s7_y_64", fld(hy[2], 0), 448);
    chk("s7_ybounce", hbp[2][0], 1);
    tick();
    chk("s7_y_65", fld(obj_y, 0), 441);
    repeat (82 - 65) tick();
    chk("s7_x_82", fld(obj_x, 0), 574);
    tick();
    chk("s7_x_83", fld(hx[2], 0), 576);
    chk("s7_xbounce", hbp[2][0], 1);

    // Overrun on a tick while busy; sticky; pause ignored.
    do_reset();
    speed = 3'd3;
    sb_q.push_back(model_step(3));
    frame_tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("ovr_set", overrun, 1);
    chk("ovr_one_step_x", fld(obj_x, 0), mx[0]);
    repeat (5) @(posedge clk);
    #1;
    chk("ovr_sticky", overrun, 1);
    pause_tick();
    chk("pause_obj0_x", fld(obj_x, 0), mx[0]);
    chk("pause_obj1_y", fld(obj_y, 1), my[1]);
    chk("pause_ovr_kept", overrun, 1);
    do_reset();
    pause_tick();
    chk("pause_no_ovr", overrun, 0);
    chk("pause_rst_obj1_x", fld(obj_x, 1), 64);

    // Zero speed at a wall.
    speed = 3'd4;
    repeat (8) tick();
    chk("wall_obj1_y", fld(obj_y, 1), 0);
    speed = 3'd0;
    tick();
    chk("s0_no_bounce", hbp[1] | hbp[2] | hbp[3] | hbp[4], 0);
    chk("s0_obj1_y", fld(obj_y, 1), 0);

    // Reset in the middle of a pass.
    do_reset();
    speed = 3'd3;
    sb_q.push_back(model_step(3));
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    sb_q.delete();
    aborted = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) pcnt[i] = 0;
    @(negedge clk);
    check_reset_state("abort");
    @(posedge clk); #1;
    check_first_tick();

    // Randomised frames against the model.
    do_reset();
    repeat (80) begin
      r = $urandom_range(0, 9);
      speed = SPEED_W'($urandom_range(0, 7));
      if (r < 7) begin
        tick();
      end else if (r < 8) begin
        pause_tick();
      end else begin
        j = $urandom_range(0, N - 1);
        h = mx[j] + int'($urandom_range(0, OBJ_W + 3)) - 2;
        v = my[j] + int'($urandom_range(0, OBJ_H + 3)) - 2;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        hpos = POS_W'(h); vpos = POS_W'(v); #1;
        chk("rand_hit", hit, model_hit(h, v));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
